mem_port_arbiter: RTL

Shares the single-port Ram between two requesters: the instruction-fetch path (IF) and the load/store path (LS) of the control FSM. It arbitrates per access, drives the Ram address/data/write-enable bus and routes read data back to the owner. At most one read is outstanding, and a starvation guard bounds how long fetch can be blocked by data traffic.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter_read_return_pipe.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and limits for the Ram port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWNER_NONE,
      OWNER_IF,
      OWNER_LS
   } MemOwner;

   typedef enum logic {
      ARB_IDLE,
      ARB_WAIT
   } ArbState;

   // Longest supported Ram read latency; sizes the return-pipe counter.
   localparam int unsigned MAX_MEM_LATENCY = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and Ram bus signals shared between the arbiter and its neighbours.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side.
   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_addr, mem_we, mem_wdata
   );

   // Requester / Ram side.
   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter_read_return_pipe.sv
// Tracks the single outstanding read and routes captured Ram data to its owner.
module read_return_pipe
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue,
   input  MemOwner           issue_owner,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wait_done,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata
);
   localparam int unsigned CNT_W = $clog2(MAX_MEM_LATENCY + 1);

   logic [CNT_W-1:0] lat_q;
   MemOwner          owner_q;
   logic             capture;
   MemOwner          cap_owner;

   // Ram data is captured in the issue cycle for latency 1, else when the count reaches 1.
   always_comb begin
      capture   = 1'b0;
      cap_owner = OWNER_NONE;
      if (MEM_LATENCY == 1) begin
         capture   = issue;
         cap_owner = issue_owner;
      end else if (lat_q == CNT_W'(1)) begin
         capture   = 1'b1;
         cap_owner = owner_q;
      end
   end

   assign wait_done = (lat_q == CNT_W'(1));

   // Latency countdown and owner tag for the read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_q   <= '0;
         owner_q <= OWNER_NONE;
      end else if (issue && (MEM_LATENCY > 1)) begin
         lat_q   <= CNT_W'(MEM_LATENCY - 1);
         owner_q <= issue_owner;
      end else if (lat_q != '0) begin
         lat_q <= lat_q - CNT_W'(1);
         if (lat_q == CNT_W'(1)) owner_q <= OWNER_NONE;
      end
   end

   // One-cycle rvalid pulse and held rdata for the owning port only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         if_rdata  <= '0;
         ls_rdata  <= '0;
      end else begin
         if_rvalid <= capture && (cap_owner == OWNER_IF);
         ls_rvalid <= capture && (cap_owner == OWNER_LS);
         if (capture && (cap_owner == OWNER_IF)) if_rdata <= mem_rdata;
         if (capture && (cap_owner == OWNER_LS)) ls_rdata <= mem_rdata;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port Ram between instruction fetch and load/store with a starvation guard.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   ArbState    state_q, state_d;
   logic [3:0] starve_q;
   logic       if_gnt, ls_gnt, read_issue, wait_done;
   MemOwner    issue_owner;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ARB_IDLE;
      else        state_q <= state_d;
   end

   // Stay idle for stores and latency-1 reads; otherwise wait out the read.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: if (read_issue && (MEM_LATENCY > 1)) state_d = ARB_WAIT;
         ARB_WAIT: if (wait_done) state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   // Grant selection and Ram bus drive from the winner.
   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (state_q == ARB_IDLE) begin
         if (bus.if_req && bus.ls_req) begin
            if (starve_q == 4'(STARVE_LIMIT)) if_gnt = 1'b1;
            else                              ls_gnt = 1'b1;
         end else begin
            if_gnt = bus.if_req;
            ls_gnt = bus.ls_req;
         end
      end
      read_issue  = if_gnt || (ls_gnt && !bus.ls_we);
      issue_owner = if_gnt ? OWNER_IF : (ls_gnt ? OWNER_LS : OWNER_NONE);
      if (if_gnt) begin
         bus.mem_addr  = bus.if_addr;
         bus.mem_we    = 1'b0;
         bus.mem_wdata = '0;
      end else if (ls_gnt) begin
         bus.mem_addr  = bus.ls_addr;
         bus.mem_we    = bus.ls_we;
         bus.mem_wdata = bus.ls_wdata;
      end else begin
         bus.mem_addr  = '0;
         bus.mem_we    = 1'b0;
         bus.mem_wdata = '0;
      end
   end

   assign bus.if_gnt = if_gnt;
   assign bus.ls_gnt = ls_gnt;

   // Counts LS grants that bypass a waiting fetch, saturating at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        starve_q <= '0;
      else if (!bus.if_req || if_gnt)    starve_q <= '0;
      else if (ls_gnt && (starve_q != 4'(STARVE_LIMIT)))
                                         starve_q <= starve_q + 4'd1;
   end

   read_return_pipe #(
      .DATA_W      (DATA_W),
      .MEM_LATENCY (MEM_LATENCY)
   ) u_ret (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue       (read_issue),
      .issue_owner (issue_owner),
      .mem_rdata   (bus.mem_rdata),
      .wait_done   (wait_done),
      .if_rvalid   (bus.if_rvalid),
      .if_rdata    (bus.if_rdata),
      .ls_rvalid   (bus.ls_rvalid),
      .ls_rdata    (bus.ls_rdata)
   );
endmodule
